down_count_timer: RTL and testbench

- Programmable down-counting timer. It consumes a loaded count one step per clock edge and reports expiry.
- It is the counterpart of the team's free-running up-counter driven by `always @(posedge clk)`. That block produces a count; this block loads a count and drains it to zero.
- Used as a period/delay generator for testbenches and small controllers in the codebase.
- Supports pause/resume, one-shot or auto-reload operation, and an expiry event counter.

---
 rtl/down_count_timer.sv | 133 +++++++++++++
 tb/tb_down_count_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down-counter with pause/resume, one-shot or
// auto-reload operation, and a wrapping expiry event counter.
module down_count_timer #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ECNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              start,
  input  logic              stop,
  input  logic              auto_reload,
  output logic [WIDTH-1:0]  count,
  output logic              running,
  output logic              done,
  output logic              expire,
  output logic [ECNT_W-1:0] expire_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   reload_reg;
  logic [WIDTH-1:0]   reload_n;
  logic [WIDTH-1:0]   count_n;
  logic               expire_n;
  logic [ECNT_W-1:0]  ecnt_n;

  logic count_zero;
  logic count_one;
  logic reload_zero;

  assign count_zero  = (count == '0);
  assign count_one   = (count == WIDTH'(1));
  assign reload_zero = (reload_reg == '0);

  // State register; running/done are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      running <= (state_n == S_RUN);
      done    <= (state_n == S_DONE);
    end
  end

  // Next-state logic; priority is load > stop > start > count step
  always_comb begin
    state_n = state;
    if (load) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !count_zero) state_n = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_n = S_PAUSE;
          end else if (count_zero) begin
            // Unreachable in normal operation; park safely rather than underflow
            state_n = S_DONE;
          end else if (count_one && !auto_reload) begin
            state_n = S_DONE;
          end
        end
        S_PAUSE: begin
          if (start) state_n = S_RUN;
        end
        S_DONE: begin
          if (start && !reload_zero) state_n = S_RUN;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath next values: count, reload register, expiry pulse and counter
  always_comb begin
    count_n  = count;
    reload_n = reload_reg;
    expire_n = 1'b0;
    ecnt_n   = expire_cnt;
    if (load) begin
      reload_n = load_val;
      count_n  = load_val;
    end else begin
      case (state)
        S_RUN: begin
          if (!stop && !count_zero) begin
            if (count_one) begin
              expire_n = 1'b1;
              ecnt_n   = expire_cnt + ECNT_W'(1);
              count_n  = auto_reload ? reload_reg : '0;
            end else begin
              count_n  = count - WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          if (start && !reload_zero) count_n = reload_reg;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      reload_reg <= '0;
      expire     <= 1'b0;
      expire_cnt <= '0;
    end else begin
      count      <= count_n;
      reload_reg <= reload_n;
      expire     <= expire_n;
      expire_cnt <= ecnt_n;
    end
  end

endmodule

// File: tb/tb_down_count_timer.sv
// tb_down_count_timer: directed vectors with hand-computed expectations.
// A second instance with a 2-bit expiry counter shares all inputs so the
// counter wrap can be observed.
module tb_down_count_timer;

  localparam int unsigned WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              start;
  logic              stop;
  logic              auto_reload;
  logic [WIDTH-1:0]  count;
  logic              running;
  logic              done;
  logic              expire;
  logic [15:0]       expire_cnt;
  logic [WIDTH-1:0]  count2;
  logic              running2;
  logic              done2;
  logic              expire2;
  logic [1:0]        expire_cnt2;

  int checks;
  int errors;

  down_count_timer #(.WIDTH(WIDTH), .ECNT_W(16)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count), .running(running), .done(done),
    .expire(expire), .expire_cnt(expire_cnt)
  );

  down_count_timer #(.WIDTH(WIDTH), .ECNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count2), .running(running2), .done(done2),
    .expire(expire2), .expire_cnt(expire_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1; load_val = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    int exp_cnt[12];
    int exp_exp[12];
    checks = 0; errors = 0;
    rst = 1'b0; load_val = '0; auto_reload = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst_count", count, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_expire", expire, 0);
    check("rst_ecnt", expire_cnt, 0);

    // Asynchronous reset mid-count: 10 -> start -> 9,8,7,6 then rst
    do_load(10);
    do_start();
    check("midrst_run", running, 1);
    repeat (4) cyc();
    check("midrst_pre_count", count, 6);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_count", count, 0);
    check("midrst_running", running, 0);
    check("midrst_done", done, 0);
    check("midrst_expire", expire, 0);
    rst = 1'b0;
    cyc();

    // One-shot: load 5, start, then 4,3,2,1,0 with expire on reaching 0
    auto_reload = 1'b0;
    do_load(5);
    check("os_load_count", count, 5);
    check("os_load_expire", expire, 0);
    do_start();
    check("os_start_count", count, 5);
    check("os_start_running", running, 1);
    for (int i = 4; i >= 1; i--) begin
      cyc();
      check("os_count", count, 64'(i));
      check("os_expire_low", expire, 0);
    end
    cyc();
    check("os_final_count", count, 0);
    check("os_expire", expire, 1);
    check("os_done", done, 1);
    check("os_running", running, 0);
    check("os_ecnt", expire_cnt, 1);
    cyc();
    check("os_expire_drop", expire, 0);
    check("os_done_hold", done, 1);
    check("os_count_hold", count, 0);
    // DONE + start restarts from the reload value
    do_start();
    check("done_restart_count", count, 5);
    check("done_restart_running", running, 1);
    check("done_restart_done", done, 0);

    // Periodic: load 3, auto-reload, 12 cycles -> 4 pulses
    do_reset();
    auto_reload = 1'b1;
    do_load(3);
    do_start();
    exp_cnt = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    exp_exp = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("per_count", count, 64'(exp_cnt[i]));
      check("per_expire", expire, 64'(exp_exp[i]));
      check("per_done", done, 0);
    end
    check("per_ecnt", expire_cnt, 4);
    check("per_running", running, 1);

    // Pause and priority
    do_reset();
    auto_reload = 1'b0;
    do_load(8);
    do_start();
    repeat (3) cyc();
    check("pause_pre", count, 5);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("pause_running", running, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("pause_hold", count, 5);
    end
    do_start();
    check("resume_state_only", count, 5);
    check("resume_running", running, 1);
    start = 1'b1; stop = 1'b1;
    cyc();
    check("run_stopwins_count", count, 5);
    check("run_stopwins_running", running, 0);
    cyc();
    check("pause_startwins_running", running, 1);
    check("pause_startwins_count", count, 5);
    start = 1'b0; stop = 1'b0;
    cyc();
    check("resume_dec1", count, 4);
    cyc();
    check("resume_dec2", count, 3);

    // Load with start in the same cycle: load wins, IDLE with new value
    load = 1'b1; load_val = 7; start = 1'b1;
    cyc();
    idle_inputs();
    check("ldstart_count", count, 7);
    check("ldstart_running", running, 0);
    check("ldstart_expire", expire, 0);

    // Load 0 then start: stays IDLE, no expiry
    do_reset();
    do_load(0);
    do_start();
    check("zero_running", running, 0);
    cyc();
    check("zero_count", count, 0);
    check("zero_expire", expire, 0);
    check("zero_done", done, 0);

    // Load 1 with auto-reload: expire every cycle; 2-bit counter wraps
    do_reset();
    auto_reload = 1'b1;
    do_load(1);
    do_start();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("r1_expire", expire, 1);
      check("r1_count", count, 1);
      check("r1_ecnt", expire_cnt, 64'(i));
      check("wrap_ecnt", expire_cnt2, 64'(i % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
